// File: rtl/onehot_decoder_ctrl_pkg.sv
// Shared constants and state encoding for the timed one-hot decoder.
// The decode widths and the counter width live here so the top and the decoder agree.
package onehot_decoder_ctrl_pkg;

  localparam int CODE_W   = 3;
  localparam int ONEHOT_W = 1 << CODE_W;
  localparam int CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/onehot_decoder_ctrl_bin2onehot.sv
// Purely combinational binary-to-one-hot decode.
// The top module registers this decoder's output when it accepts a code.
module bin2onehot
  import onehot_decoder_ctrl_pkg::*;
#(
  parameter int IN_W  = CODE_W,
  parameter int OUT_W = ONEHOT_W
) (
  input  logic [IN_W-1:0]  code,
  output logic [OUT_W-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_decoder_ctrl.sv
// Registered 3-to-8 one-hot decoder with a valid/ready handshake.
// Each accepted code drives its line for HOLD_CYCLES clocks, followed by GAP_CYCLES zero clocks.
module onehot_decoder_ctrl
  import onehot_decoder_ctrl_pkg::*;
#(
  parameter int IN_W        = CODE_W,
  parameter int OUT_W       = ONEHOT_W,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  in,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;
  logic [OUT_W-1:0]   out_nxt;
  logic [OUT_W-1:0]   decoded;
  logic               done_nxt;
  logic               accept;

  bin2onehot #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_dec (
    .code   (in),
    .onehot (decoded)
  );

  assign in_ready = (state == IDLE) && en;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    out_nxt   = out;
    done_nxt  = 1'b0;
    case (state)
      IDLE: begin
        out_nxt = '0;
        if (accept) begin
          out_nxt   = decoded;
          state_nxt = HOLD;
          cnt_nxt   = HOLD_LOAD;
        end
      end
      HOLD: begin
        // A dropped enable ends the window early and suppresses done.
        if (!en || (cnt == '0)) begin
          out_nxt  = '0;
          done_nxt = en;
          if (GAP_CYCLES > 0) begin
            state_nxt = GAP;
            cnt_nxt   = GAP_LOAD;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      GAP: begin
        out_nxt = '0;
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        out_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      out   <= out_nxt;
      done  <= done_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_onehot_decoder_ctrl.sv
// Scoreboard bench: a timestamp-based reference model queues per-cycle expectations,
// a monitor pops and compares them; a second instance covers the HOLD=1/GAP=0 build.
module tb_onehot_decoder_ctrl;

  localparam int H = 4;
  localparam int G = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       in_valid = 1'b0;
  logic [2:0] in = 3'd0;
  logic       in_ready;
  logic [7:0] out;
  logic       busy;
  logic       done;

  logic       rst2 = 1'b1;
  logic       in_ready2;
  logic [7:0] out2;
  logic       busy2;
  logic       done2;
  int         ph2 = 0;

  always #5 clk = ~clk;

  onehot_decoder_ctrl #(.HOLD_CYCLES(H), .GAP_CYCLES(G)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in(in),
    .in_ready(in_ready), .out(out), .busy(busy), .done(done)
  );

  onehot_decoder_ctrl #(.HOLD_CYCLES(1), .GAP_CYCLES(0)) dut2 (
    .clk(clk), .rst(rst2), .en(1'b1), .in_valid(1'b1), .in(3'd1),
    .in_ready(in_ready2), .out(out2), .busy(busy2), .done(done2)
  );

  typedef struct packed {
    logic [7:0] out;
    logic       busy;
    logic       done;
    logic       idle;
  } exp_t;

  exp_t q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: windows described by absolute edge numbers.
  int         n = 0;
  int         acc_edge = -1;
  int         clr_edge = -1;
  int         idle_edge = -1;
  bit         aborted = 1'b0;
  logic [2:0] code = 3'd0;

  task automatic model_step();
    exp_t e;
    n = n + 1;
    if (rst) begin
      acc_edge = -1; clr_edge = -1; idle_edge = -1; aborted = 1'b0;
    end else if (n > idle_edge) begin
      if (en && in_valid) begin
        acc_edge = n; code = in; clr_edge = n + H; idle_edge = n + H + G; aborted = 1'b0;
      end
    end else if (n <= clr_edge && !en) begin
      clr_edge = n; idle_edge = n + G; aborted = 1'b1;
    end
    e.out  = (n >= acc_edge && n < clr_edge) ? (8'h01 << code) : 8'h00;
    e.done = (n == clr_edge) && !aborted;
    e.busy = (n < idle_edge);
    e.idle = (n >= idle_edge);
    q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s t=%0t actual{out,busy,done,rdy}=%h required=%h", name, $time, act, req);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("main", {out, busy, done, in_ready}, {e.out, e.busy, e.done, e.idle && en});
    end
  end

  always @(posedge clk) begin
    if (rst2) ph2 <= 0;
    else      ph2 <= ph2 + 1;
  end

  initial forever begin
    @(negedge clk);
    if (!rst2 && ph2 >= 1 && ph2 <= 40) begin
      if (ph2 % 2 == 1) check("h1g0", {out2, busy2, done2, in_ready2}, {8'h02, 1'b1, 1'b0, 1'b0});
      else              check("h1g0", {out2, busy2, done2, in_ready2}, {8'h00, 1'b0, 1'b1, 1'b1});
    end
  end

  task automatic tick(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [2:0] c);
    bit ok;
    ok = 1'b0;
    en = 1'b1; in_valid = 1'b1; in = c;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      tick(1);
    end
    in_valid = 1'b0;
    in = 3'($urandom);
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout code=%0d actual=not_accepted required=accepted", c);
    end
  endtask

  initial begin
    tick(3);
    rst = 1'b0; rst2 = 1'b0;
    send(3'd5);
    tick(7);
    for (int c = 0; c < 8; c++) send(3'(c));
    tick(7);
    send(3'd2);
    tick(1);
    en = 1'b0;
    tick(4);
    en = 1'b1;
    tick(3);
    send(3'd7);
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send(3'd3);
    tick(7);
    en = 1'b0; in_valid = 1'b1; in = 3'd4;
    tick(10);
    en = 1'b1;
    tick(8);
    in_valid = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      en       = ($urandom % 8) != 0;
      in_valid = ($urandom % 2) != 0;
      in       = 3'($urandom);
      rst      = ($urandom % 64) == 0;
      tick(1);
    end
    rst = 1'b0; en = 1'b1; in_valid = 1'b0;
    tick(10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_ctrl.md
Name: onehot_decoder_ctrl

Overview:
- Registered 3-to-8 one-hot decoder with a valid/ready input handshake and a timed output window.
- Accepts a binary code and drives the matching one-hot line for exactly HOLD_CYCLES clocks, then forces GAP_CYCLES clocks of all-zero dead time.
- Serves as the driving end for the team's 8:3 priority/one-hot encoder path: select lines, demux enables, loopback checking.

Parameters:
- IN_W, 3, code width; fixed at 3 for this block.
- OUT_W, 8, one-hot width; must equal 2**IN_W.
- HOLD_CYCLES, 4, clocks a decoded line stays high; legal range 1..255.
- GAP_CYCLES, 1, all-zero clocks after each hold; legal range 0..255.

Ports:
- clk  input  1  single clock; all logic is rising-edge.
- rst  input  1  synchronous, active-high reset.
- en  input  1  block enable; low blocks acceptance and aborts an active hold.
- in_valid  input  1  code on `in` is valid.
- in  input  3  binary code 0..7.
- in_ready  output  1  block can accept a code this cycle.
- out  output  8  registered one-hot output; bit[in] set during hold.
- busy  output  1  high in HOLD or GAP.
- done  output  1  one-cycle pulse when a hold completes normally.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out=8'h00, done=0, busy=0, counter=0. Reset mid-hold clears `out` at that same edge; no done pulse is issued.
- FSM states are IDLE, HOLD and GAP. The down-counter is 8 bits wide.
- in_ready = (state==IDLE) & en. It is combinational from registered state only and never depends on in_valid.
- Accept: in_valid & in_ready at edge t. Then:
  - out <= 8'h01 << in
  - state <= HOLD
  - counter <= HOLD_CYCLES-1
  - The code is captured; later changes on `in` are ignored.
- Latency: `out` is valid in the cycle after the accepting edge and stays stable for exactly HOLD_CYCLES cycles.
- HOLD with counter!=0: decrement the counter.
- HOLD with counter==0 at an edge:
  - out <= 0, done <= 1 for one cycle.
  - If GAP_CYCLES>0: state <= GAP, counter <= GAP_CYCLES-1.
  - Otherwise: state <= IDLE.
- GAP: out=0. The counter decrements; when it reaches 0, state <= IDLE.
- Minimum accept-to-accept spacing is HOLD_CYCLES+GAP_CYCLES+1 clocks. A code cannot be accepted on the same edge the FSM returns to IDLE.
- en low during HOLD (sampled at an edge):
  - out <= 0 and the abort is immediate; no done pulse.
  - Go to GAP with counter=GAP_CYCLES-1, or to IDLE if GAP_CYCLES==0.
- en low during GAP: GAP runs to completion.
- en low in IDLE: in_ready=0, so in_valid is ignored.
- Simultaneous rst and accept: reset wins.
- busy = (state!=IDLE), registered.
- Invariant: `out` has at most one bit set in every cycle, and it is all-zero outside HOLD.

Decomposition:
- Shared package/include holds:
  - state encoding localparams: IDLE=2'd0, HOLD=2'd1, GAP=2'd2;
  - the constant OUT_W = 1<<IN_W.
- One natural sub-module, `bin2onehot`: purely combinational 3-to-8 decode. The top registers its output on accept.
- FSM and counter live in the top.

Test Plan:
- Reset, then in=3'd5 with in_valid=1 and en=1 -> in_ready=1; out=8'h20 for exactly 4 cycles; done pulses on the 5th cycle while out=0; 1 gap cycle; then in_ready=1 again.
- Sweep in=0..7, each held valid until accepted -> out sequence 01,02,04,08,10,20,40,80, with out=0 and in_ready=0 between windows and spacing of exactly 6 clocks.
- Accept in=3'd2, then drop en on the 2nd HOLD cycle -> out=0 at the next edge; no done pulse; GAP entered; in_ready stays 0 until en=1 and IDLE.
- Accept in=3'd7, then assert rst on the 3rd HOLD cycle -> out=0, busy=0, done=0 after that edge; a new code is accepted 1 cycle after rst falls.
- With en=0, drive in_valid=1 and in=3'd4 for 10 cycles -> in_ready=0 and out=0 throughout; raising en accepts on the next edge.
- GAP_CYCLES=0, HOLD_CYCLES=1 build, in_valid held high with in=3'd1 -> out=8'h02 pulses one cycle high, one cycle low, repeating; done is high on each low cycle.
